// File: rtl/uart_alu_interface.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_alu_interface
// Brief   : Collects an A/B/opcode byte frame from the UART receiver, drives
//           the ALU operands, and hands the ALU result to the UART transmitter.
// Revision: 1.0 - initial release
// ============================================================================
module uart_alu_interface #(
  parameter int N_BITS         = 8,
  parameter int N_OPCODE       = 6,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_rx_done_tick,
  input  logic [N_BITS-1:0]   i_rx_data,
  input  logic [N_BITS-1:0]   i_alu_result,
  input  logic                i_tx_done_tick,
  output logic [N_BITS-1:0]   o_alu_a,
  output logic [N_BITS-1:0]   o_alu_b,
  output logic [N_OPCODE-1:0] o_alu_op,
  output logic [N_BITS-1:0]   o_tx_data,
  output logic                o_tx_start,
  output logic                o_busy,
  output logic                o_timeout,
  output logic                o_overrun
);

  localparam int c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_CALC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 w_in_frame;
  logic                 w_expired;
  logic                 w_timeout_hit;
  logic                 w_next_busy;

  assign w_in_frame    = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
  assign w_expired     = (r_cnt == c_CNT_LAST);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign w_timeout_hit = w_in_frame && w_expired && !i_rx_done_tick;
  assign w_next_busy   = (w_next_state == ST_CALC) || (w_next_state == ST_SEND) ||
                         (w_next_state == ST_WAIT_TX);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_WAIT_A;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_WAIT_A:  if (i_rx_done_tick) w_next_state = ST_WAIT_B;
      ST_WAIT_B:  begin
        if (i_rx_done_tick)     w_next_state = ST_WAIT_OP;
        else if (w_timeout_hit) w_next_state = ST_WAIT_A;
      end
      ST_WAIT_OP: begin
        if (i_rx_done_tick)     w_next_state = ST_CALC;
        else if (w_timeout_hit) w_next_state = ST_WAIT_A;
      end
      ST_CALC:    w_next_state = ST_SEND;
      ST_SEND:    w_next_state = ST_WAIT_TX;
      ST_WAIT_TX: if (i_tx_done_tick) w_next_state = ST_WAIT_A;
      default:    w_next_state = ST_WAIT_A;
    endcase
  end

  // Counter only advances while staying in a frame-collecting state; any
  // accepted byte or state change clears it.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (w_in_frame && (w_next_state == r_state)) begin
      r_cnt <= r_cnt + c_CNT_ONE;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_tx_start <= (w_next_state == ST_SEND);
      o_busy     <= w_next_busy;
      case (r_state)
        ST_WAIT_A: begin
          if (i_rx_done_tick) begin
            o_alu_a   <= i_rx_data;
            o_timeout <= 1'b0;
            o_overrun <= 1'b0;
          end
        end
        ST_WAIT_B: begin
          if (i_rx_done_tick)     o_alu_b   <= i_rx_data;
          else if (w_timeout_hit) o_timeout <= 1'b1;
        end
        ST_WAIT_OP: begin
          if (i_rx_done_tick)     o_alu_op  <= i_rx_data[N_OPCODE-1:0];
          else if (w_timeout_hit) o_timeout <= 1'b1;
        end
        ST_CALC: begin
          o_tx_data <= i_alu_result;
          if (i_rx_done_tick) o_overrun <= 1'b1;
        end
        default: begin
          if (i_rx_done_tick) o_overrun <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_interface.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_uart_alu_interface
// Brief   : Self-checking bench: directed vector table, corner sequences and a
//           randomized frame stream against a frame-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_alu_interface;

  localparam int N_BITS   = 8;
  localparam int N_OPCODE = 6;
  localparam int TIMEOUT  = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                rx_done_tick;
  logic [N_BITS-1:0]   rx_data;
  logic [N_BITS-1:0]   alu_result;
  logic                tx_done_tick;
  logic [N_BITS-1:0]   alu_a;
  logic [N_BITS-1:0]   alu_b;
  logic [N_OPCODE-1:0] alu_op;
  logic [N_BITS-1:0]   tx_data;
  logic                tx_start;
  logic                busy;
  logic                timeout_flag;
  logic                overrun_flag;

  int n_cmp = 0;
  int n_err = 0;
  int n_starts = 0;

  always #5 clk = ~clk;

  uart_alu_interface #(
    .N_BITS(N_BITS), .N_OPCODE(N_OPCODE), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_rx_done_tick(rx_done_tick),
    .i_rx_data(rx_data), .i_alu_result(alu_result), .i_tx_done_tick(tx_done_tick),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .o_tx_data(tx_data),
    .o_tx_start(tx_start), .o_busy(busy), .o_timeout(timeout_flag),
    .o_overrun(overrun_flag)
  );

  // ALU semantics used both by the stub and by the reference model.
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);

  always @(negedge clk) if (tx_start) n_starts++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got time-limit expiry expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
  endtask

  task automatic pulse_tx_done(input bit with_rx, input logic [7:0] b);
    tx_done_tick = 1'b1;
    if (with_rx) begin rx_data = b; rx_done_tick = 1'b1; end
    tick();
    tx_done_tick = 1'b0; rx_done_tick = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {alu_a, alu_b, 2'b00, alu_op, tx_data, tx_start, busy, timeout_flag, overrun_flag},
        64'd0);
  endtask

  // Called right after the opcode byte has been accepted.
  task automatic finish_frame(input string name, input logic [7:0] exp_tx);
    int s0;
    s0 = n_starts;
    chk({name, "_busy_calc"}, {busy, tx_start}, 2'b10);
    tick();
    chk({name, "_start_send"}, {tx_start, tx_data}, {1'b1, exp_tx});
    tick();
    repeat ($urandom_range(0, 3)) tick();
    pulse_tx_done(1'b0, 8'h00);
    chk({name, "_idle_after_done"}, busy, 1'b0);
    chk({name, "_one_start"}, n_starts - s0, 1);
  endtask

  typedef struct {
    logic [7:0] a, b, op_byte;
    logic [7:0] exp_a, exp_b;
    logic [5:0] exp_op;
    logic [7:0] exp_tx;
  } vec_t;

  vec_t vecs[5];

  logic [7:0] ma, mb, mop, mexp, rb;
  bit         mtmo, movr, both;
  int         q, frames, gap, s0;

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h05, 8'h03, 6'h20, 8'h08};
    vecs[1] = '{8'h10, 8'h04, 8'hE2, 8'h10, 8'h04, 6'h22, 8'h0C};
    vecs[2] = '{8'hFF, 8'h01, 8'h20, 8'hFF, 8'h01, 6'h20, 8'h00};
    vecs[3] = '{8'h07, 8'h09, 8'h3F, 8'h07, 8'h09, 6'h3F, 8'h0E};
    vecs[4] = '{8'h80, 8'h80, 8'h60, 8'h80, 8'h80, 6'h20, 8'h00};

    rst_n = 1'b0; rx_done_tick = 1'b0; tx_done_tick = 1'b0; rx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_values");
    rst_n = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 5; i++) begin
      send_byte(vecs[i].a);
      chk("vec_a", alu_a, vecs[i].exp_a);
      send_byte(vecs[i].b);
      chk("vec_b", alu_b, vecs[i].exp_b);
      send_byte(vecs[i].op_byte);
      chk("vec_op", alu_op, vecs[i].exp_op);
      finish_frame("vec", vecs[i].exp_tx);
    end

    // Inter-byte timeout after one byte, then a full frame
    send_byte(8'h11);
    repeat (TIMEOUT - 1) tick();
    chk("tmo_not_yet", timeout_flag, 1'b0);
    tick();
    chk("tmo_set", {timeout_flag, busy}, 2'b10);
    send_byte(8'h01);
    chk("tmo_new_a", {alu_a, timeout_flag}, {8'h01, 1'b0});
    send_byte(8'h02);
    send_byte(8'h03);
    chk("tmo_frame_ops", {alu_a, alu_b, alu_op}, {8'h01, 8'h02, 6'h03});
    finish_frame("tmo_frame", 8'h03);

    // Byte exactly on the expiry cycle, in WAIT_B and in WAIT_OP
    send_byte(8'h21);
    repeat (TIMEOUT - 1) tick();
    send_byte(8'h22);
    chk("edge_b", {alu_b, timeout_flag}, {8'h22, 1'b0});
    repeat (TIMEOUT - 1) tick();
    send_byte(8'h20);
    chk("edge_op", {alu_op, timeout_flag}, {6'h20, 1'b0});
    finish_frame("edge_frame", 8'h43);

    // Overrun during WAIT_TX
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h22);
    tick(); tick(); tick();
    send_byte(8'hAA);
    chk("ovr_set", {overrun_flag, busy, alu_a, alu_b}, {1'b1, 1'b1, 8'h05, 8'h06});
    pulse_tx_done(1'b0, 8'h00);
    chk("ovr_idle", {busy, overrun_flag}, 2'b01);
    send_byte(8'h44);
    chk("ovr_clear", {alu_a, overrun_flag}, {8'h44, 1'b0});
    send_byte(8'h01); send_byte(8'h20);
    tick(); tick(); tick();
    // tx_done and a byte together: byte is an overrun, frame still ends
    pulse_tx_done(1'b1, 8'h99);
    chk("both_pulses", {busy, overrun_flag, alu_a}, {1'b0, 1'b1, 8'h44});
    send_byte(8'h12);
    chk("both_next_a", {alu_a, overrun_flag}, {8'h12, 1'b0});
    send_byte(8'h34); send_byte(8'h20);
    finish_frame("post_both", 8'h46);

    // Reset during WAIT_TX, then during CALC
    for (int k = 0; k < 2; k++) begin
      send_byte(8'h31); send_byte(8'h32); send_byte(8'h20);
      s0 = n_starts;
      if (k == 0) begin tick(); tick(); tick(); end
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_async");
      tick();
      rst_n = 1'b1;
      repeat (8) tick();
      chk("rst_no_start", n_starts - s0, (k == 0) ? 1 : 0);
      chk_all_zero("rst_after");
      send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h20);
      finish_frame("rst_frame", 8'h15);
    end

    // Randomized stream against the frame-level model
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    ma = 0; mb = 0; mop = 0; mtmo = 0; movr = 0; q = 0; frames = 0;
    for (int it = 0; it < 600 && frames < 40; it++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 4)
                                        : $urandom_range(0, 4);
      repeat (gap) tick();
      if (q > 0 && gap >= TIMEOUT) begin mtmo = 1; q = 0; end
      chk("rnd_timeout", timeout_flag, mtmo);
      rb = 8'($urandom);
      send_byte(rb);
      if (q == 0) begin
        ma = rb; mtmo = 0; movr = 0; q = 1;
      end else if (q == 1) begin
        mb = rb; q = 2;
      end else begin
        mop = {2'b00, rb[5:0]}; q = 3;
      end
      chk("rnd_ops", {alu_a, alu_b, alu_op, timeout_flag, overrun_flag},
          {ma, mb, mop[5:0], mtmo, movr});
      if (q == 3) begin
        q = 0;
        mexp = alu_fn(ma, mb, mop[5:0]);
        s0 = n_starts;
        chk("rnd_busy", busy, 1'b1);
        tick();
        chk("rnd_send", {tx_start, tx_data}, {1'b1, mexp});
        tick();
        repeat ($urandom_range(0, 2)) begin
          repeat ($urandom_range(0, 2)) tick();
          send_byte(8'($urandom));
          movr = 1;
          chk("rnd_overrun", {overrun_flag, busy, alu_a, alu_b}, {movr, 1'b1, ma, mb});
        end
        repeat ($urandom_range(0, 3)) tick();
        both = ($urandom_range(0, 3) == 0);
        if (both) movr = 1;
        pulse_tx_done(both, 8'($urandom));
        chk("rnd_done", {busy, overrun_flag, tx_data, alu_a}, {1'b0, movr, mexp, ma});
        chk("rnd_one_start", n_starts - s0, 1);
        frames++;
      end
    end
    chk("rnd_frames_done", frames, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
